// File: rtl/light_sequencer.sv
// light_sequencer
//   Push-button RGB LED colour sequencer. The advance button is synchronised,
//   debounced and edge-detected; each debounced press steps a registered
//   colour state machine OFF -> RED -> GREEN -> BLUE -> WHITE -> RED -> ...
//
// Parameters
//   CLK_HZ       : board clock frequency in Hz (informational only)
//   BOUNCE_TICKS : consecutive cycles the synchronised button must disagree
//                  with the debounced level before that level changes (>= 2)
//
// Ports
//   clk     : system clock, all state changes on the rising edge
//   buttons : [0] synchronous active-high reset (used unsynchronised)
//             [1] asynchronous, bouncy advance button
//   rgb     : registered LED drive, active-high, [2]=red [1]=green [0]=blue
module light_sequencer #(
  parameter int CLK_HZ       = 12_000_000,
  parameter int BOUNCE_TICKS = 8
) (
  input  logic       clk,
  input  logic [1:0] buttons,
  output logic [2:0] rgb
);

  localparam int CW = (BOUNCE_TICKS > 1) ? $clog2(BOUNCE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BOUNCE_TICKS - 1);

  // State encodings double as the LED pattern, so rgb is the state register.
  localparam logic [2:0] ST_OFF   = 3'b000;
  localparam logic [2:0] ST_RED   = 3'b100;
  localparam logic [2:0] ST_GREEN = 3'b010;
  localparam logic [2:0] ST_BLUE  = 3'b001;
  localparam logic [2:0] ST_WHITE = 3'b111;

  if (BOUNCE_TICKS < 2 || CLK_HZ < 1) begin : g_bad_param
    $error("light_sequencer: BOUNCE_TICKS must be >= 2 and CLK_HZ positive");
  end

  logic          rst;
  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] counter;
  logic [2:0]    state;
  logic [2:0]    state_next;
  logic          press;

  assign rst   = buttons[0];
  assign press = stable & ~stable_d;
  assign rgb   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      counter  <= '0;
      state    <= ST_OFF;
    end else begin
      sync1    <= buttons[1];
      sync2    <= sync1;
      // Any return to the debounced level restarts the qualification count.
      if (sync2 == stable) begin
        counter <= '0;
      end else if (counter == CNT_MAX) begin
        stable  <= sync2;
        counter <= '0;
      end else begin
        counter <= counter + CW'(1);
      end
      stable_d <= stable;
      state    <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_OFF:   if (press) state_next = ST_RED;
      ST_RED:   if (press) state_next = ST_GREEN;
      ST_GREEN: if (press) state_next = ST_BLUE;
      ST_BLUE:  if (press) state_next = ST_WHITE;
      ST_WHITE: if (press) state_next = ST_RED;
      default:  state_next = ST_OFF;
    endcase
  end

endmodule

// File: tb/tb_light_sequencer.sv
// tb_light_sequencer
//   Directed self-checking bench for light_sequencer with BOUNCE_TICKS = 8.
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_light_sequencer;

  localparam int BT = 8;

  logic       clk;
  logic [1:0] btn;
  logic [2:0] rgb;

  int n_checks;
  int n_fail;

  light_sequencer #(
    .CLK_HZ      (12_000_000),
    .BOUNCE_TICKS(BT)
  ) dut (
    .clk    (clk),
    .buttons(btn),
    .rgb    (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish (actual running, required done)");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    btn = 2'b01;
    step();
    step();
    btn = 2'b00;
    n_checks++;
    if (rgb !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_rgb: got %b expected 000", rgb);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (rgb !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got %b expected 000", i, rgb);
      end
    end
  endtask

  task automatic test_clean_press();
    btn[1] = 1'b1;
    for (int e = 1; e <= BT + 3; e++) begin
      step();
      if (e == BT + 1) begin
        n_checks++;
        if (dut.stable !== 1'b0) begin
          n_fail++;
          $display("FAIL clean_stable_early: got %b expected 0 at edge %0d", dut.stable, e);
        end
      end
      if (e == BT + 2) begin
        n_checks++;
        if (dut.stable !== 1'b1) begin
          n_fail++;
          $display("FAIL clean_stable_rise: got %b expected 1 at edge %0d", dut.stable, e);
        end
      end
      n_checks++;
      if (rgb !== ((e < BT + 3) ? 3'b000 : 3'b100)) begin
        n_fail++;
        $display("FAIL clean_latency: edge %0d got %b expected %b", e, rgb,
                 (e < BT + 3) ? 3'b000 : 3'b100);
      end
    end
    repeat (250) step();
    n_checks++;
    if (rgb !== 3'b100) begin
      n_fail++;
      $display("FAIL clean_hold: got %b expected 100", rgb);
    end
    btn[1] = 1'b0;
    repeat (250) step();
    n_checks++;
    if (rgb !== 3'b100) begin
      n_fail++;
      $display("FAIL clean_release: got %b expected 100", rgb);
    end
  endtask

  task automatic bounce_to(input logic val);
    int n;
    n = $urandom_range(29, 10);
    for (int i = 0; i < n; i++) begin
      #($urandom_range(15, 1));
      btn[1] = ~btn[1];
    end
    btn[1] = val;
    repeat (250) step();
  endtask

  task automatic test_bouncy_sequence();
    logic [2:0] exp_seq [5];
    exp_seq = '{3'b100, 3'b010, 3'b001, 3'b111, 3'b100};
    btn = 2'b01;
    step();
    step();
    btn = 2'b00;
    step();
    for (int p = 0; p < 5; p++) begin
      bounce_to(1'b1);
      n_checks++;
      if (rgb !== exp_seq[p]) begin
        n_fail++;
        $display("FAIL bouncy_press[%0d]: got %b expected %b", p, rgb, exp_seq[p]);
      end
      bounce_to(1'b0);
      n_checks++;
      if (rgb !== exp_seq[p]) begin
        n_fail++;
        $display("FAIL bouncy_release[%0d]: got %b expected %b", p, rgb, exp_seq[p]);
      end
    end
  endtask

  task automatic test_glitch_reject();
    btn[1] = 1'b1;
    repeat (BT - 2) step();
    btn[1] = 1'b0;
    step();
    step();
    n_checks++;
    if (dut.counter !== 3'd6) begin
      n_fail++;
      $display("FAIL glitch_count_peak: got %0d expected 6", dut.counter);
    end
    step();
    n_checks++;
    if (dut.counter !== 3'd0) begin
      n_fail++;
      $display("FAIL glitch_count_clear: got %0d expected 0", dut.counter);
    end
    repeat (20) step();
    n_checks++;
    if (rgb !== 3'b100) begin
      n_fail++;
      $display("FAIL glitch_rgb: got %b expected 100", rgb);
    end
  endtask

  task automatic test_bounce_restart();
    btn[1] = 1'b1;
    repeat (BT - 1) step();
    btn[1] = 1'b0;
    step();
    btn[1] = 1'b1;
    for (int e = 1; e <= BT + 3; e++) begin
      step();
      n_checks++;
      if (rgb !== ((e < BT + 3) ? 3'b100 : 3'b010)) begin
        n_fail++;
        $display("FAIL restart_latency: edge %0d got %b expected %b", e, rgb,
                 (e < BT + 3) ? 3'b100 : 3'b010);
      end
    end
    btn[1] = 1'b0;
    repeat (30) step();
    n_checks++;
    if (rgb !== 3'b010) begin
      n_fail++;
      $display("FAIL restart_release: got %b expected 010", rgb);
    end
  endtask

  task automatic test_back_to_back();
    btn[1] = 1'b1;
    repeat (20) step();
    btn[1] = 1'b0;
    repeat (20) step();
    n_checks++;
    if (rgb !== 3'b001) begin
      n_fail++;
      $display("FAIL to_blue: got %b expected 001", rgb);
    end
  endtask

  task automatic test_reset_mid_op();
    btn[1] = 1'b1;
    repeat (6) step();
    n_checks++;
    if (dut.counter !== 3'd4) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d expected 4", dut.counter);
    end
    btn = 2'b01;
    step();
    n_checks++;
    if (rgb !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_rgb: got %b expected 000", rgb);
    end
    n_checks++;
    if (dut.counter !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset_counter: got %0d expected 0", dut.counter);
    end
    btn = 2'b00;
    repeat (30) step();
    n_checks++;
    if (rgb !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_after: got %b expected 000", rgb);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    btn      = 2'b01;
    #1;
    test_reset();
    test_clean_press();
    test_bouncy_sequence();
    test_glitch_reject();
    test_bounce_restart();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
Name: light_sequencer

Overview:
- Push-button driven RGB LED colour sequencer for the 12 MHz board clock.
- `buttons[1]` is a mechanical "advance" button. It is synchronised, debounced, and each debounced press (rising edge) steps a registered colour state machine that drives a 3-bit RGB LED.
- `buttons[0]` is the board's reset button and acts as the block's synchronous, active-high reset.

Parameters:
- CLK_HZ, 12_000_000, clock frequency in Hz (documentation only; no logic depends on it).
- BOUNCE_TICKS, 8, consecutive clock cycles the synchronised button must differ from the debounced value before the debounced value changes; legal range ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- buttons  input  2  `[0]` = reset: synchronous, active-high, used directly without a synchroniser. `[1]` = advance button, asynchronous and bouncy.
- rgb  output  3  LED drive, registered, active-high: `[2]` = red, `[1]` = green, `[0]` = blue.

Behaviour:
- One clock; reset is synchronous and active-high (`clk`, with `buttons[0]` as the reset input).
- Reset (`buttons[0]` == 1 at a rising edge) clears all state:
  - sync1, sync2, debounced (stable), stable_d and counter → 0
  - state → OFF, so rgb = 3'b000
- Reset dominates all other activity. Asserting reset mid-bounce or mid-count discards the pending press.
- Synchroniser: two flops, sync1 <= buttons[1] and sync2 <= sync1.
- Debouncer, evaluated each edge when not in reset:
  - If sync2 == stable: counter <= 0.
  - Else if counter == BOUNCE_TICKS-1: stable <= sync2 and counter <= 0.
  - Else: counter <= counter + 1.
  - Counter width is clog2(BOUNCE_TICKS) bits; it never wraps past BOUNCE_TICKS-1.
  - Any bounce that returns sync2 to the stable value restarts the count.
- Edge detect: stable_d <= stable. A press is stable & ~stable_d.
- Release (falling edge of stable) has no effect on the colour.
- Latency: take the first edge that samples buttons[1] high, with the input clean from then on, as edge 1.
  - stable rises at edge BOUNCE_TICKS+2.
  - rgb takes its new value at edge BOUNCE_TICKS+3.
  - Exactly one advance per debounced press, regardless of hold time.
- State machine, advancing on press:
  - OFF (000) → RED (100) → GREEN (010) → BLUE (001) → WHITE (111) → RED (100), and so on.
  - OFF is entered only via reset.
  - After leaving OFF, the sequence wraps WHITE → RED indefinitely.
- rgb is driven directly from registered state; no combinational path from buttons to rgb.
- Glitch rejection: pulses on buttons[1] shorter than BOUNCE_TICKS consecutive synchronised cycles produce no change.
- Sub-cycle bounce between edges is invisible by construction.
- An unknown or invalid state encoding recovers to OFF on the next edge (default arm).

Test Plan:
- Reset: hold `buttons[0]`=1 for 2 edges with `buttons[1]`=0, then release → rgb == 3'b000 and stays 000 for 20 idle cycles.
- Clean press: after reset, drive `buttons[1]`=1 cleanly → rgb changes 000→100 exactly at edge BOUNCE_TICKS+3 (edge 11 with the default), and is still 100 after holding 250 cycles. Releasing then waiting 250 cycles → rgb still 100.
- Bouncy press sequence: 5 press/release pairs, each preceded by 10–29 random toggles at 1–15 ns spacing, held 250 cycles per phase.
  - rgb after each press: 100, 010, 001, 111, 100.
  - Releases never change rgb.
- Glitch rejection: from RED, pulse `buttons[1]` high for BOUNCE_TICKS-2 cycles, then low → rgb remains 100. Counter returns to 0 one edge after sync2 returns to 0.
- Bounce restarts count: high for BOUNCE_TICKS-1 cycles, low 1 cycle, high steady → advance occurs BOUNCE_TICKS+3 edges after the final rising sample, not earlier.
- Reset mid-operation: from BLUE, press and assert `buttons[0]` at debounce count 4 → rgb == 000 on that edge. No advance occurs after reset release while the button stays low.
